// File: rtl/operand_entry_pkg.sv
// Shared state encodings and default timing for the operand entry path.
package operand_entry_pkg;

    typedef enum logic [1:0] {
        ST_GET_A = 2'd0,
        ST_GET_B = 2'd1,
        ST_GET_C = 2'd2,
        ST_SHOW  = 2'd3
    } state_t;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_CNT_W           = 19;

endpackage

// File: rtl/key_debouncer.sv
// Synchronises and debounces an active-low pushbutton; emits one press pulse per accepted press.
// Press pulse appears DEBOUNCE_CYCLES+3 edges after the key is first sampled low.
module key_debouncer
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            level_d <= level;
            // Only a falling debounced level counts as a press; releases are silent.
            press   <= level_d & ~level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_entry_fsm.sv
// Collects a, b, c and carry-in over three key presses and commits them to the adder atomically.
// Outputs update DEBOUNCE_CYCLES+4 edges after a press is first sampled; switch motion between presses is ignored.
module operand_entry_fsm
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] sw,
    input  logic       sw_cin,
    input  logic       key_n,
    output logic [1:0] a,
    output logic [1:0] b,
    output logic [1:0] c,
    output logic       cin,
    output logic       operands_valid,
    output logic [1:0] stage
);

    state_t     state;
    state_t     state_next;
    logic       press;
    logic [1:0] sw_s1;
    logic [1:0] sw_s2;
    logic       cin_s1;
    logic       cin_s2;
    logic [1:0] hold_a;
    logic [1:0] hold_b;
    logic       cap_a;
    logic       cap_b;
    logic       commit;
    logic       wrap;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key (
        .clock (clock),
        .reset (reset),
        .key_n (key_n),
        .press (press)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            cin_s1 <= 1'b0;
            cin_s2 <= 1'b0;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            cin_s1 <= sw_cin;
            cin_s2 <= cin_s1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_GET_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (press) begin
            case (state)
                ST_GET_A: state_next = ST_GET_B;
                ST_GET_B: state_next = ST_GET_C;
                ST_GET_C: state_next = ST_SHOW;
                ST_SHOW:  state_next = ST_GET_A;
                default:  state_next = ST_GET_A;
            endcase
        end
    end

    always_comb begin
        cap_a  = press && (state == ST_GET_A);
        cap_b  = press && (state == ST_GET_B);
        commit = press && (state == ST_GET_C);
        wrap   = press && (state == ST_SHOW);
        stage  = state;
    end

    // a/b/c/cin move together on commit so the adder never sees a mixed set.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_a         <= '0;
            hold_b         <= '0;
            a              <= '0;
            b              <= '0;
            c              <= '0;
            cin            <= 1'b0;
            operands_valid <= 1'b0;
        end else begin
            if (cap_a) hold_a <= sw_s2;
            if (cap_b) hold_b <= sw_s2;
            if (commit) begin
                a              <= hold_a;
                b              <= hold_b;
                c              <= sw_s2;
                cin            <= cin_s2;
                operands_valid <= 1'b1;
            end
            if (wrap) begin
                operands_valid <= 1'b0;
                hold_a         <= '0;
                hold_b         <= '0;
            end
        end
    end

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed and randomized checks of operand_entry_fsm against a press-level reference model.
module tb_operand_entry_fsm;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] sw;
    logic       sw_cin;
    logic       key_n;
    logic [1:0] a, b, c;
    logic       cin;
    logic       operands_valid;
    logic [1:0] stage;

    int total = 0;
    int bad   = 0;

    operand_entry_fsm #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .sw             (sw),
        .sw_cin         (sw_cin),
        .key_n          (key_n),
        .a              (a),
        .b              (b),
        .c              (c),
        .cin            (cin),
        .operands_valid (operands_valid),
        .stage          (stage)
    );

    always #5 clock = ~clock;

    // Reference model: key sample seen two edges late, accepted after D
    // consecutive differing samples, outputs move two edges after acceptance.
    typedef struct {
        int         at;
        logic [1:0] s;
        logic       ci;
    } adv_t;

    adv_t       pend[$];
    int         edge_no = 0;
    logic       kd1, kd2, lvl;
    int         run;
    int         m_stage;
    logic [1:0] m_ha, m_hb, m_a, m_b, m_c;
    logic       m_cin, m_valid;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_press(input logic [1:0] s, input logic ci);
        case (m_stage)
            0: begin m_ha = s; m_stage = 1; end
            1: begin m_hb = s; m_stage = 2; end
            2: begin
                m_a = m_ha; m_b = m_hb; m_c = s; m_cin = ci;
                m_valid = 1'b1; m_stage = 3;
            end
            default: begin m_valid = 1'b0; m_ha = 0; m_hb = 0; m_stage = 0; end
        endcase
    endtask

    task automatic model_edge();
        logic seen;
        adv_t ev;
        edge_no++;
        if (reset) begin
            kd1 = 1'b1; kd2 = 1'b1; lvl = 1'b1; run = 0;
            pend.delete();
            m_stage = 0; m_ha = 0; m_hb = 0; m_a = 0; m_b = 0; m_c = 0;
            m_cin = 0; m_valid = 0;
            return;
        end
        while (pend.size() > 0 && pend[0].at == edge_no) begin
            ev = pend.pop_front();
            apply_press(ev.s, ev.ci);
        end
        seen = kd2;
        kd2  = kd1;
        kd1  = key_n;
        if (seen !== lvl) begin
            run++;
            if (run == D) begin
                lvl = seen;
                run = 0;
                if (seen == 1'b0) begin
                    ev.at = edge_no + 2; ev.s = sw; ev.ci = sw_cin;
                    pend.push_back(ev);
                end
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        chk("stage", stage, 8'(m_stage));
        chk("valid", operands_valid, m_valid);
        chk("a", a, m_a);
        chk("b", b, m_b);
        chk("c", c, m_c);
        chk("cin", cin, m_cin);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic [1:0] s, input logic ci, input int hold, input int rel);
        sw = s; sw_cin = ci; key_n = 1'b0;
        ticks(hold);
        key_n = 1'b1;
        ticks(rel);
    endtask

    task automatic tick_rnd(input logic k);
        key_n  = k;
        sw     = 2'($urandom);
        sw_cin = 1'($urandom);
        tick();
    endtask

    initial begin
        reset = 1'b1; key_n = 1'b1; sw = 2'd0; sw_cin = 1'b0;
        ticks(2);
        reset = 1'b0;
        chk("rst_stage", stage, 0);
        chk("rst_valid", operands_valid, 0);
        chk("rst_a", a, 0);
        chk("rst_cin", cin, 0);

        // Latency: key sampled low first at edge 1, stage moves exactly at edge 8.
        sw = 2'b10; key_n = 1'b0;
        ticks(7);
        chk("lat_edge7", stage, 0);
        tick();
        chk("lat_edge8", stage, 1);
        ticks(12);
        key_n = 1'b1;
        ticks(20);

        press(2'b01, 1'b0, 20, 20);
        chk("pre_commit_a", a, 0);
        chk("pre_commit_valid", operands_valid, 0);
        press(2'b11, 1'b1, 20, 20);
        chk("full_a", a, 2);
        chk("full_b", b, 1);
        chk("full_c", c, 3);
        chk("full_cin", cin, 1);
        chk("full_valid", operands_valid, 1);
        chk("full_stage", stage, 3);

        // Long hold in SHOW wraps once and keeps committed values.
        press(2'b00, 1'b0, 100, 20);
        chk("wrap_stage", stage, 0);
        chk("wrap_valid", operands_valid, 0);
        chk("wrap_a", a, 2);
        chk("wrap_b", b, 1);
        chk("wrap_c", c, 3);
        chk("wrap_cin", cin, 1);

        // Bounces shorter than D never register.
        key_n = 0; ticks(3); key_n = 1; ticks(2); key_n = 0; ticks(2); key_n = 1; ticks(20);
        chk("bounce_none", stage, 0);
        for (int i = 0; i < 5; i++) begin
            key_n = 0; tick(); key_n = 1; tick();
        end
        key_n = 0; ticks(10); key_n = 1; ticks(20);
        chk("bounce_one", stage, 1);

        press(2'b10, 1'b1, 20, 20);
        chk("mid_stage2", stage, 2);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_reset", stage, 0);
        chk("mid_reset_a", a, 0);
        ticks(5);
        for (int i = 0; i < 3; i++) press(2'b01, 1'b0, 20, 20);
        chk("reentry_a", a, 1);
        chk("reentry_b", b, 1);
        chk("reentry_c", c, 1);
        chk("reentry_cin", cin, 0);
        chk("reentry_valid", operands_valid, 1);

        // Reset coincides with the edge where the press would advance the FSM.
        ticks(5);
        press(2'b00, 1'b0, 0, 0);
        key_n = 1'b0; ticks(7);
        reset = 1'b1; key_n = 1'b1; tick(); reset = 1'b0;
        ticks(20);
        chk("reset_wins", stage, 0);

        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1; tick(); reset = 1'b0;
            end
            for (int n = $urandom_range(0, 3); n > 0; n--) begin
                for (int i = $urandom_range(1, D - 1); i > 0; i--) tick_rnd(1'b0);
                for (int i = $urandom_range(1, D - 1); i > 0; i--) tick_rnd(1'b1);
            end
            for (int i = $urandom_range(1, 14); i > 0; i--) tick_rnd(1'b0);
            for (int i = $urandom_range(1, 14); i > 0; i--) tick_rnd(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_entry_fsm.md
Name: operand_entry_fsm

Overview:
Upstream stage of the three-operand 2-bit adder / seven-segment path. Collects operands a, b, c and carry-in from the board slide switches over three debounced pushbutton presses. Presents all four values to the adder atomically, with a valid flag. Owns switch/key synchronisation and debounce, so the adder stays purely combinational.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a key level change is accepted (10 ms at 50 MHz); must be >= 2
CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clock  input  1  system clock, all flops rising-edge
reset  input  1  synchronous, active-high reset
sw  input  2  operand value from slide switches, asynchronous
sw_cin  input  1  carry-in switch, asynchronous, captured with operand c
key_n  input  1  pushbutton, active-low, asynchronous, bouncy
a  output  2  committed operand a to adder
b  output  2  committed operand b to adder
c  output  2  committed operand c to adder
cin  output  1  committed carry-in to adder
operands_valid  output  1  high while a/b/c/cin hold a complete committed set
stage  output  2  current FSM state for LED indication (0=GET_A, 1=GET_B, 2=GET_C, 3=SHOW)

Behaviour:
- Reset, synchronous, active-high: a=b=c=0, cin=0, operands_valid=0, stage=0 (GET_A). Holding registers and debounce counter cleared. Both synchroniser stages and the debounced level set to 1 (released). Press pulse cleared. Reset mid-entry discards partial operands.
- Synchronisers: key_n, sw and sw_cin each pass through two flops before use.
- Debounce: counter increments each cycle the synchronised key differs from the debounced level. Counter clears to 0 when they are equal. When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synchronised value and the counter clears. Glitches shorter than DEBOUNCE_CYCLES cycles have no effect.
- Press event: one-cycle registered pulse on debounced 1->0 transition. Exactly one pulse per press, however long the key is held. No event on release.
- Latency: key_n stable low first sampled at edge 1 -> press pulse high in the cycle after edge DEBOUNCE_CYCLES+3 -> FSM state/outputs update at edge DEBOUNCE_CYCLES+4.
- FSM (advances only on press pulse; otherwise holds):
  - GET_A: capture synchronised sw into hold_a -> GET_B.
  - GET_B: capture sw into hold_b -> GET_C.
  - GET_C: on the same edge, load a<=hold_a, b<=hold_b, c<=sw, cin<=sw_cin; operands_valid<=1 -> SHOW.
  - SHOW: operands_valid<=0, clear hold registers -> GET_A. a/b/c/cin keep their last committed values until the next commit.
- a/b/c/cin change only on the GET_C->SHOW edge (atomic commit). The adder never sees a mixed set.
- Switch movement between presses is ignored. Only the value at the press-pulse cycle is captured.
- Reset and press pulse asserted in the same cycle: reset wins.

Decomposition:
- Shared package operand_entry_pkg:
  - state encodings ST_GET_A=2'd0, ST_GET_B=2'd1, ST_GET_C=2'd2, ST_SHOW=2'd3
  - default DEBOUNCE_CYCLES
- Sub-module key_debouncer: 2-flop synchroniser, counter, debounced level and press pulse; parameters DEBOUNCE_CYCLES, CNT_W; ports clock, reset, key_n, press. Instantiated once.
- FSM, switch synchronisers and output registers stay in operand_entry_fsm.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset: assert reset 2 cycles with key_n=1 -> a=b=c=0, cin=0, operands_valid=0, stage=0.
- Full entry: press with sw=2'b10, then 2'b01, then 2'b11 with sw_cin=1; each press held 20 cycles, 20 cycles released between -> after third press a=2, b=1, c=3, cin=1, operands_valid=1, stage=3. a/b/c unchanged (0) before the third press commits.
- Latency: key_n falls at edge 1 and stays low -> stage changes 0->1 exactly at edge 8 (DEBOUNCE_CYCLES+4).
- Bounce rejection: key_n pulses low 3 cycles, high 2, low 2, then high -> no press pulse, stage stays 0. A single press with 5 bounces before settling low for 10 cycles -> exactly one stage increment.
- Hold and wrap: key held low 100 cycles in SHOW -> single transition to GET_A, operands_valid=0, a/b/c/cin retain prior values (2,1,3,1).
- Reset mid-entry: after two presses (stage=2), assert reset 1 cycle -> stage=0. A subsequent three-press entry with sw=1,1,1 and sw_cin=0 commits a=b=c=1, cin=0.
